// File: rtl/serial_word_tx_if.sv
// Word handshake and serial output bundle for serial_word_tx.
// master: upstream word source (and observer of the serial side).
// slave:  the transmitter itself.
interface serial_word_tx_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             serial_out;
    logic             busy;
    logic             frame_done;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, serial_out, busy, frame_done
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, serial_out, busy, frame_done
    );
endinterface

// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter.
// Accepts one WIDTH-bit word on a valid/ready handshake and shifts it out
// MSB-first, one bit per clock. The line is then held low for GAP_CYCLES
// guard cycles before the next word is accepted. All outputs are registered,
// so there is no combinational path from tx_valid to tx_ready.
module serial_word_tx #(
    parameter int WIDTH      = 16,
    parameter int GAP_CYCLES = 2
) (
    input logic          clk,
    input logic          rst_n,
    serial_word_tx_if.slave bus
);
    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] BIT_LOAD = CNT_W'(WIDTH - 1);
    // Gap counter holds "remaining guard cycles minus one" on entry to GAP.
    localparam logic [7:0]      GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] bit_cnt;
    logic [7:0]       gap_cnt;

    // Single FSM: sequencing, shifting and all registered outputs.
    // NOTE: every register here is updated with <= so all reads see the
    // pre-edge values; a blocking = would let later lines see half-updated state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            shreg          <= '0;
            bit_cnt        <= '0;
            gap_cnt        <= '0;
            bus.tx_ready   <= 1'b0;
            bus.serial_out <= 1'b0;
            bus.busy       <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.serial_out <= 1'b0;
                    bus.busy       <= 1'b0;
                    bus.frame_done <= 1'b0;
                    bus.tx_ready   <= 1'b1;
                    // Handshake uses the registered ready, so the first edge
                    // after reset only raises tx_ready.
                    if (bus.tx_valid && bus.tx_ready) begin
                        state          <= SHIFT;
                        shreg          <= bus.tx_data;
                        bit_cnt        <= BIT_LOAD;
                        bus.serial_out <= bus.tx_data[WIDTH-1];
                        bus.tx_ready   <= 1'b0;
                        bus.busy       <= 1'b1;
                    end
                end

                SHIFT: begin
                    if (bit_cnt != '0) begin
                        // Present the next lower bit; frame_done marks word bit 0.
                        shreg          <= {shreg[WIDTH-2:0], 1'b0};
                        bus.serial_out <= shreg[WIDTH-2];
                        bit_cnt        <= bit_cnt - 1'b1;
                        bus.frame_done <= (bit_cnt == CNT_W'(1));
                    end else begin
                        // Last bit has been on the line for one cycle.
                        bus.serial_out <= 1'b0;
                        bus.frame_done <= 1'b0;
                        if (GAP_CYCLES > 0) begin
                            state   <= GAP;
                            gap_cnt <= GAP_LOAD;
                        end else begin
                            state        <= IDLE;
                            bus.busy     <= 1'b0;
                            bus.tx_ready <= 1'b1;
                        end
                    end
                end

                GAP: begin
                    bus.serial_out <= 1'b0;
                    bus.frame_done <= 1'b0;
                    if (gap_cnt == 8'd0) begin
                        state        <= IDLE;
                        bus.busy     <= 1'b0;
                        bus.tx_ready <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end

                default: begin
                    state          <= IDLE;
                    bus.serial_out <= 1'b0;
                    bus.busy       <= 1'b0;
                    bus.frame_done <= 1'b0;
                    bus.tx_ready   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_word_tx.sv
// Testbench for serial_word_tx: a GAP_CYCLES=2 instance and a GAP_CYCLES=0
// instance share one clock/reset; one is active per phase. Expected output
// states are queued when a handshake is driven and popped edge by edge.
module tb_serial_word_tx;
    localparam int W = 16;

    typedef struct packed {
        logic ser;
        logic fd;
        logic busy;
        logic rdy;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic [W-1:0] data  = '0;
    logic         valid = 1'b0;
    bit           sel0  = 1'b0;   // 1: drive/check the GAP_CYCLES=0 instance
    int           gap   = 2;

    serial_word_tx_if #(.WIDTH(W)) bus2 ();
    serial_word_tx_if #(.WIDTH(W)) bus0 ();

    assign bus2.tx_data  = sel0 ? '0 : data;
    assign bus2.tx_valid = !sel0 && valid;
    assign bus0.tx_data  = sel0 ? data : '0;
    assign bus0.tx_valid = sel0 && valid;

    serial_word_tx #(.WIDTH(W), .GAP_CYCLES(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
    serial_word_tx #(.WIDTH(W), .GAP_CYCLES(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

    always #5 clk = ~clk;

    exp_t q[$];
    exp_t cur = '0;
    int   n_vec = 0;
    int   n_err = 0;
    int   edge_cnt = 0;
    logic last_rdy = 1'b0;
    int   obs_hs[$];

    function automatic exp_t observe();
        exp_t o;
        if (sel0) o = '{ser: bus0.serial_out, fd: bus0.frame_done, busy: bus0.busy, rdy: bus0.tx_ready};
        else      o = '{ser: bus2.serial_out, fd: bus2.frame_done, busy: bus2.busy, rdy: bus2.tx_ready};
        return o;
    endfunction

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_vec++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s at edge %0d: observed=%0h expected=%0h", tag, edge_cnt, o, e);
        end
    endtask

    task automatic compare();
        exp_t o;
        o = observe();
        check("serial_out", 32'(o.ser),  32'(cur.ser));
        check("frame_done", 32'(o.fd),   32'(cur.fd));
        check("busy",       32'(o.busy), 32'(cur.busy));
        check("tx_ready",   32'(o.rdy),  32'(cur.rdy));
        last_rdy = o.rdy;
    endtask

    // Advance n edges: update the expectation model, then sample 1 ns later.
    task automatic step(input int n);
        exp_t e;
        repeat (n) begin
            @(posedge clk);
            edge_cnt++;
            if (rst_n) begin
                if (valid && last_rdy) obs_hs.push_back(edge_cnt);
                if (valid && cur.rdy) begin
                    for (int i = W - 1; i >= 0; i--) begin
                        e = '{ser: data[i], fd: (i == 0), busy: 1'b1, rdy: 1'b0};
                        q.push_back(e);
                    end
                    for (int i = 0; i < gap; i++) begin
                        e = '{ser: 1'b0, fd: 1'b0, busy: 1'b1, rdy: 1'b0};
                        q.push_back(e);
                    end
                end
                if (q.size() > 0) cur = q.pop_front();
                else              cur = '{ser: 1'b0, fd: 1'b0, busy: 1'b0, rdy: 1'b1};
            end
            #1;
            compare();
        end
    endtask

    // Asynchronous reset taken mid-cycle: outputs must drop at once.
    task automatic do_reset();
        rst_n = 1'b0;
        q.delete();
        cur = '0;
        #1;
        compare();
        step(3);
        rst_n = 1'b1;
    endtask

    initial begin
        int base;

        // Reset then idle.
        #1;
        compare();
        step(3);
        rst_n = 1'b1;
        step(5);

        // Single word with gap.
        data  = 16'hA5C3;
        valid = 1'b1;
        step(1);
        valid = 1'b0;
        step(W + 2 + 3);
        check("single_hs_count", 32'(obs_hs.size()), 32'd1);

        // Back-to-back with tx_valid held; data changes while shifting.
        base  = obs_hs.size();
        data  = 16'hFFFF;
        valid = 1'b1;
        step(1);
        data  = 16'h0001;
        step(W + 2 + 1);
        valid = 1'b0;
        step(W + 2 + 3);
        check("b2b_hs_count", 32'(obs_hs.size() - base), 32'd2);
        if (obs_hs.size() - base == 2)
            check("b2b_spacing", 32'(obs_hs[base+1] - obs_hs[base]), 32'd19);

        // Ignore tx_valid/tx_data activity while busy.
        base  = obs_hs.size();
        data  = 16'hA5C3;
        valid = 1'b1;
        step(1);
        for (int i = 0; i < W + 2; i++) begin
            valid = 1'($urandom_range(0, 1));
            data  = W'($urandom);
            step(1);
        end
        valid = 1'b0;
        step(3);
        check("busy_ignore_hs_count", 32'(obs_hs.size() - base), 32'd1);

        // GAP_CYCLES=0 instance: two words with tx_valid held.
        valid = 1'b0;
        sel0  = 1'b1;
        gap   = 0;
        do_reset();
        step(2);
        base  = obs_hs.size();
        data  = 16'h8001;
        valid = 1'b1;
        step(1 + W + 1);
        valid = 1'b0;
        step(W + 3);
        check("gap0_hs_count", 32'(obs_hs.size() - base), 32'd2);
        if (obs_hs.size() - base == 2)
            check("gap0_spacing", 32'(obs_hs[base+1] - obs_hs[base]), 32'd17);

        // Reset mid-word, then a clean word.
        sel0 = 1'b0;
        gap  = 2;
        do_reset();
        step(2);
        data  = 16'hFFFF;
        valid = 1'b1;
        step(1);
        valid = 1'b0;
        step(6);
        #2;
        do_reset();
        step(1);
        base  = obs_hs.size();
        data  = 16'h1234;
        valid = 1'b1;
        step(1);
        valid = 1'b0;
        step(W + 2 + 3);
        check("post_reset_hs_count", 32'(obs_hs.size() - base), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/serial_word_tx.md
Name: serial_word_tx

Overview:
Parallel-to-serial transmitter that feeds the 16-bit serial shift/decode stage. It accepts one WIDTH-bit word via a valid/ready handshake and drives it MSB-first on a single serial line, one bit per clock. It then holds the line low for a programmable guard gap before accepting the next word. Word bit 0 is the last bit shifted, so a downstream register that shifts in at its LSB holds the word aligned after WIDTH cycles.

Parameters:
WIDTH, 16, word length in bits; legal range 2..64.
GAP_CYCLES, 2, idle-low guard cycles after each word; legal range 0..255.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
tx_data  input  WIDTH  word to transmit; sampled only on handshake.
tx_valid  input  1  upstream has a word on tx_data.
tx_ready  output  1  block can accept a word; registered.
serial_out  output  1  serial data to the downstream data_in; registered.
busy  output  1  high while in SHIFT or GAP; registered.
frame_done  output  1  one-cycle pulse, coincident with the last bit on serial_out.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; shift register, bit counter and gap counter are 0.
  - tx_ready=0, serial_out=0, busy=0, frame_done=0.
  - tx_ready rises on the first rising edge after rst_n deasserts.
  - Reset mid-word aborts the word. No partial word is resumed or flagged.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - serial_out=0, busy=0, tx_ready=1.
  - Handshake = tx_valid && tx_ready at a rising edge (E0). At E0 the block latches tx_data, moves to SHIFT, and sets tx_ready=0, busy=1, serial_out=tx_data[WIDTH-1], bit counter=WIDTH-1.
  - If tx_valid is low, the block stays in IDLE.
  - tx_data changes while not handshaking are ignored.
- SHIFT:
  - Each edge shifts left and presents the next lower bit. After edge E(k), serial_out = word[WIDTH-1-k] for k=0..WIDTH-1.
  - frame_done=1 exactly in the cycle serial_out carries word[0], i.e. after E(WIDTH-1).
  - At E(WIDTH):
    - GAP_CYCLES>0: go to GAP with gap counter=GAP_CYCLES-1.
    - GAP_CYCLES=0: go to IDLE.
  - In both cases serial_out=0 and frame_done=0.
  - tx_valid is ignored during SHIFT and GAP.
- GAP:
  - serial_out=0, busy=1, tx_ready=0.
  - The gap counter decrements each edge. When it is 0, the next edge enters IDLE with tx_ready=1 and busy=0.
- Timing:
  - tx_ready returns high after edge E(WIDTH+GAP_CYCLES).
  - Minimum handshake-to-handshake spacing is WIDTH+GAP_CYCLES+1 cycles.
  - Latency from handshake edge to first bit on serial_out is 1 edge (visible right after E0).
- Width rules: bit counter is clog2(WIDTH) bits; gap counter is 8 bits. Neither counter wraps; each is reloaded on entry to its state.
- Simultaneous events: tx_valid rising in the same cycle tx_ready rises is accepted on that edge. No combinational path exists from tx_valid to tx_ready.

Test Plan:
- Reset then idle: hold rst_n low 3 cycles, release with tx_valid=0 for 5 cycles -> outputs all 0 during reset; tx_ready=1 from first edge after release; serial_out=0 throughout.
- Single word: WIDTH=16, GAP=2, tx_data=16'hA5C3 with tx_valid=1 -> serial_out over 16 cycles = 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1. frame_done=1 only on the final '1'. Then 2 cycles of 0, then tx_ready=1 after E18.
- Back-to-back: tx_valid held high with 16'hFFFF then 16'h0001 -> second handshake exactly 19 cycles after the first; the two words are separated by exactly 2 zero bits; busy high for 18 cycles per word.
- Ignore while busy: toggle tx_valid and change tx_data during SHIFT and GAP -> serial stream still 16'hA5C3; no extra handshake.
- GAP_CYCLES=0 build: send 16'h8001 twice with tx_valid held -> pattern 1, fourteen 0s, 1, one idle 0, then 1; handshake spacing 17 cycles.
- Reset mid-word: assert rst_n low after 7 bits of 16'hFFFF -> serial_out, busy and tx_ready drop to 0 immediately. After release the next word 16'h1234 is transmitted intact from its MSB.
